// File: rtl/decode_result_arbiter.sv
// Round-robin arbiter merging four one-cycle decoded-message pulses into a single valid/ready output stream.
// Optional drop counter enabled by defining DECODE_ARB_DROP_CNT_EN.
module decode_result_arbiter #(
    parameter int unsigned DATA_W = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            src_valid,
    input  logic [4*DATA_W-1:0]   src_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_type,
    output logic [DATA_W-1:0]     out_data,
    output logic                  busy,
    output logic [15:0]           drop_count
);

    localparam int unsigned NSRC = 4;

    logic [NSRC-1:0]   slot_full;
    logic [NSRC-1:0]   slot_full_nxt;
    logic [DATA_W-1:0] slot_data [NSRC];
    logic [1:0]        rr_ptr;
    logic [1:0]        gnt_idx;
    logic              gnt_any;
    logic [NSRC-1:0]   gnt_oh;
    logic [NSRC-1:0]   cap;
    logic              out_free;
    logic              out_valid_nxt;

    // Round-robin search from rr_ptr for the first full slot when the output can take a result.
    always_comb begin : grant_search
        logic [1:0] idx;
        idx      = '0;
        out_free = !out_valid || out_ready;
        gnt_any  = 1'b0;
        gnt_idx  = rr_ptr;
        for (int k = 0; k < int'(NSRC); k++) begin
            idx = rr_ptr + 2'(k);
            if (out_free && !gnt_any && slot_full[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt_oh        = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
        cap           = src_valid & (~slot_full | gnt_oh);
        slot_full_nxt = cap | (slot_full & ~gnt_oh);
        out_valid_nxt = gnt_any | (out_valid & !out_free);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_type  <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            slot_full <= slot_full_nxt;
            out_valid <= out_valid_nxt;
            busy      <= (|slot_full_nxt) | out_valid_nxt;
            if (gnt_any) begin
                rr_ptr   <= gnt_idx + 2'd1;
                out_type <= gnt_idx;
                out_data <= slot_data[gnt_idx];
            end
        end
    end

    // Slot payloads are only meaningful while slot_full is set, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NSRC); i++) begin
            if (cap[i]) begin
                slot_data[i] <= src_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DECODE_ARB_DROP_CNT_EN
    logic [NSRC-1:0] drop;
    logic [2:0]      drop_n;
    logic [16:0]     drop_sum;

    always_comb begin
        drop     = src_valid & slot_full & ~gnt_oh;
        drop_n   = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
        drop_sum = {1'b0, drop_count} + 17'(drop_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`else
    assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_decode_result_arbiter.sv
// Directed and randomized checks of decode_result_arbiter against a queue-level behavioural model.
module tb_decode_result_arbiter;

    localparam int unsigned DW = 200;
`ifdef DECODE_ARB_DROP_CNT_EN
    localparam int EXP_DROP1 = 1;
`else
    localparam int EXP_DROP1 = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      src_valid;
    logic [4*DW-1:0] src_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_type;
    logic [DW-1:0]   out_data;
    logic            busy;
    logic [15:0]     drop_count;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    logic          m_full [4];
    logic [DW-1:0] m_data [4];
    int            m_rr;
    logic          m_ov;
    int            m_type;
    logic [DW-1:0] m_odata;
    int            m_drop;

    always #5 clk = ~clk;

    decode_result_arbiter #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_type   (out_type),
        .out_data   (out_data),
        .busy       (busy),
        .drop_count (drop_count)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [4*DW-1:0] rnd_data();
        logic [4*DW-1:0] r;
        for (int j = 0; j < 25; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
        m_rr = 0; m_ov = 1'b0; m_type = 0; m_odata = '0; m_drop = 0;
    endtask

    // One clock edge of the arbiter rules applied to the model.
    task automatic model_step(input logic [3:0] v, input logic [4*DW-1:0] d, input logic rdy);
        bit free;
        int g;
        int dropped;
        free = !m_ov || rdy;
        g = -1;
        dropped = 0;
        if (free) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && m_full[(m_rr + k) % 4]) g = (m_rr + k) % 4;
            end
        end
        if (g >= 0) begin
            m_ov = 1'b1; m_type = g; m_odata = m_data[g]; m_rr = (g + 1) % 4;
        end else if (free) begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (v[i] && (!m_full[i] || i == g)) begin
                m_full[i] = 1'b1;
                m_data[i] = d[i*DW +: DW];
            end else if (v[i]) begin
                dropped++;
            end else if (i == g) begin
                m_full[i] = 1'b0;
            end
        end
`ifdef DECODE_ARB_DROP_CNT_EN
        m_drop = (m_drop + dropped > 65535) ? 65535 : m_drop + dropped;
`endif
    endtask

    task automatic check_all();
        bit any_full;
        any_full = m_full[0] | m_full[1] | m_full[2] | m_full[3];
        chk("out_valid", DW'(out_valid), DW'(m_ov));
        if (m_ov) begin
            chk("out_type", DW'(out_type), DW'(m_type));
            chk("out_data", out_data, m_odata);
        end
        chk("busy", DW'(busy), DW'(any_full | m_ov));
        chk("drop_count", DW'(drop_count), DW'(m_drop));
    endtask

    task automatic cyc(input logic [3:0] v, input logic [4*DW-1:0] d, input logic rdy);
        src_valid = v; src_data = d; out_ready = rdy;
        @(posedge clk);
        model_step(v, d, rdy);
        #1;
        src_valid = '0;
        check_all();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_type", DW'(out_type), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_drop_count", DW'(drop_count), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4*DW-1:0] d, d2, d3, dz;
        logic [3:0]      v;
        dz = '0;
        src_valid = '0; src_data = '0; out_ready = 1'b0;

        apply_reset();

        // Single pulse in first cycle after release: 2-cycle latency, then idle.
        d = rnd_data();
        cyc(4'b0001, d, 1'b1);
        chk("single_lat1", DW'(out_valid), DW'(1'b0));
        cyc(4'b0000, dz, 1'b1);
        chk("single_valid", DW'(out_valid), DW'(1'b1));
        chk("single_type", DW'(out_type), DW'(0));
        chk("single_data", out_data, d[0 +: DW]);
        cyc(4'b0000, dz, 1'b1);
        chk("single_idle", DW'(out_valid), DW'(1'b0));

        // All four sources at once from rr_ptr=0.
        apply_reset();
        d = rnd_data();
        cyc(4'b1111, d, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0000, dz, 1'b1);
            chk("simul_type", DW'(out_type), DW'(k));
            chk("simul_data", out_data, d[k*DW +: DW]);
        end
        cyc(4'b0000, dz, 1'b1);
        chk("simul_end", DW'(out_valid), DW'(1'b0));
        chk("simul_drop", DW'(drop_count), DW'(0));

        // Backpressure hold.
        d = rnd_data();
        cyc(4'b0010, d, 1'b1);
        cyc(4'b0000, dz, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(4'b0000, dz, 1'b0);
            chk("bp_type", DW'(out_type), DW'(1));
            chk("bp_data", out_data, d[DW +: DW]);
            chk("bp_busy", DW'(busy), DW'(1'b1));
        end
        cyc(4'b0000, dz, 1'b1);

        // Overflow: three 'A' pulses with the output stalled.
        apply_reset();
        d = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
        cyc(4'b0001, d, 1'b0);
        cyc(4'b0001, d2, 1'b0);
        cyc(4'b0001, d3, 1'b0);
        chk("ovf_data", out_data, d[0 +: DW]);
        chk("ovf_drop", DW'(drop_count), DW'(EXP_DROP1));
        cyc(4'b0000, dz, 1'b1);
        chk("ovf_second", out_data, d2[0 +: DW]);
        cyc(4'b0000, dz, 1'b1);
        chk("ovf_empty", DW'(out_valid), DW'(1'b0));

        // Slot 2 granted and reloaded in the same cycle.
        d = rnd_data(); d2 = rnd_data();
        cyc(4'b0100, d, 1'b1);
        cyc(4'b0100, d2, 1'b1);
        chk("reload_first", out_data, d[2*DW +: DW]);
        chk("reload_drop", DW'(drop_count), DW'(EXP_DROP1));
        cyc(4'b0000, dz, 1'b1);
        chk("reload_type", DW'(out_type), DW'(2));
        chk("reload_new", out_data, d2[2*DW +: DW]);
        cyc(4'b0000, dz, 1'b1);

        // Reset with every slot full and an un-accepted result.
        cyc(4'b1111, rnd_data(), 1'b0);
        cyc(4'b1111, rnd_data(), 1'b0);
        chk("midrst_busy", DW'(busy), DW'(1'b1));
        chk("midrst_valid", DW'(out_valid), DW'(1'b1));
        #2;
        apply_reset();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) v[i] = ($urandom % 10) < 3;
            cyc(v, rnd_data(), ($urandom % 4) != 0);
        end
        for (int n = 0; n < 8; n++) cyc(4'b0000, dz, 1'b1);
        chk("drain_busy", DW'(busy), DW'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_result_arbiter.md
DECODE_RESULT_ARBITER -- requirements
Module: decode_result_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 200, width of each source's packed decoded-field bus.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port src_valid  input  4  one-cycle decoded pulses; bit0 add 'A', bit1 cancel 'X', bit2 delete 'D', bit3 replace 'U'.
REQ-005 SHALL have port src_data  input  4*DATA_W  packed fields; source i occupies bits [i*DATA_W +: DATA_W], sampled only when src_valid[i]=1.
REQ-006 SHALL have port out_valid  output  1  arbitrated result present.
REQ-007 SHALL have port out_ready  input  1  downstream accepts when out_valid=1 and out_ready=1.
REQ-008 SHALL have port out_type  output  2  source index of the result (0 A, 1 X, 2 D, 3 U).
REQ-009 SHALL have port out_data  output  DATA_W  fields of the result.
REQ-010 SHALL have port busy  output  1  OR of all slot-full flags and out_valid.
REQ-011 SHALL have port drop_count  output  16  count of pulses lost to overflow.

Function
REQ-012 SHALL hold one single-entry slot per source (slot_full[i], slot_data[i]).
REQ-013 SHALL capture src_data[i] into slot i when src_valid[i]=1 and slot i is empty, or is granted in the same cycle.
REQ-014 SHALL drop a pulse whose slot is full and not granted that cycle, leaving the slot contents unchanged.
REQ-015 SHALL treat the output register as free when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-016 SHALL, when the output register is free and any slot_full is set, grant exactly one full slot and load its index and data into out_type/out_data with out_valid=1 on the next edge.
REQ-017 SHALL select the grant round-robin: search from rr_ptr upward modulo 4 and take the first full slot; after a grant, rr_ptr = granted index + 1 mod 4.
REQ-018 SHALL leave rr_ptr unchanged in cycles with no grant.
REQ-019 SHALL clear out_valid when the register is free and no slot is full.
REQ-020 SHALL keep out_type/out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL not bypass from src_valid to the output: a pulse at cycle N gives out_valid no earlier than cycle N+2 (minimum latency 2).
REQ-022 SHALL clear slot i on grant unless REQ-013 reloads it in the same cycle.
REQ-023 SHALL accept any combination of the four simultaneous pulses into their separate slots without loss when the slots are empty.
REQ-024 SHALL ignore out_ready while out_valid=0.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force slot_full=0, rr_ptr=0, out_valid=0, out_type=0, out_data=0, drop_count=0; busy therefore reads 0.
REQ-026 SHALL discard pending slots and any un-accepted output on reset mid-operation, and count nothing for them.
REQ-027 SHALL need no initialisation after reset release; a pulse in the first cycle after release is captured.

Configuration
REQ-028 SHALL, with macro DECODE_ARB_DROP_CNT_EN defined, increment drop_count by the number of pulses dropped per cycle (0-4), saturating at 16'hFFFF.
REQ-029 SHALL, without DECODE_ARB_DROP_CNT_EN, tie drop_count to 16'h0000 with no counter logic; drop behaviour per REQ-014 is unchanged.

Verification
REQ-030 SHALL cover single pulse: src_valid=4'b0001 at cycle 5, out_ready=1 -> out_valid=1, out_type=0 at cycle 7 with matching data, then out_valid=0 at cycle 8.
REQ-031 SHALL cover simultaneous pulses: src_valid=4'b1111 once, out_ready=1, rr_ptr=0 -> out_type sequence 0,1,2,3 on consecutive cycles, no drops.
REQ-032 SHALL cover backpressure: out_ready=0 for 10 cycles after a 4'b0010 pulse -> out_type=1 and out_data held constant for 10 cycles; busy=1 throughout.
REQ-033 SHALL cover overflow: out_ready=0, three 'A' pulses at cycles 1,2,3 -> the first fills the output register, the second holds slot 0, the third is dropped; drop_count=1 with the macro, 0 without.
REQ-034 SHALL cover same-cycle grant and reload: slot 2 full and granted in the cycle a new 'D' pulse arrives -> new data captured, drop_count unchanged.
REQ-035 SHALL cover reset mid-stream: rst_n low with all slots full and out_valid=1 -> all outputs 0 in the same cycle, drop_count=0.
